// File: rtl/kyber_pkg.sv
// Shared constants and types for the Kyber arithmetic datapath.
package kyber_pkg;

  localparam int unsigned KYBER_Q        = 32'd3329;
  localparam int unsigned KYBER_NB_BIT   = 32'd12;
  localparam int unsigned KYBER_PROD_BIT = 32'd24;

  // Multiplier control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/adder_n.sv
// Plain NB_BIT-wide adder with carry out, used for the accumulator add.
module adder_n #(
  parameter int NB_BIT = 12
) (
  input  logic [NB_BIT-1:0] a_i,
  input  logic [NB_BIT-1:0] b_i,
  output logic              carry_o,
  output logic [NB_BIT-1:0] sum_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/mul_k.sv
// Radix-2 shift-and-add multiplier producing the unreduced product that
// feeds the mod-Q Barrett reduction stage. One operand bit per cycle.
module mul_k
  import kyber_pkg::*;
#(
  parameter int unsigned NB_BIT = KYBER_NB_BIT,
  parameter int unsigned Q      = KYBER_Q
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [NB_BIT-1:0]     a_i,
  input  logic [NB_BIT-1:0]     b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [2*NB_BIT-1:0]   product_o,
  output logic                  range_err_o
);

  localparam int unsigned PW    = 2 * NB_BIT;
  localparam int unsigned CNT_W = $clog2(NB_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB_BIT - 1);

  mul_state_e          state_q, state_d;
  logic [NB_BIT-1:0]   a_q, a_d;
  logic [NB_BIT-1:0]   b_q, b_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rerr_q, rerr_d;
  logic [PW-1:0]       prod_q, prod_d;
  logic                rerr_out_q, rerr_out_d;

  logic [PW-1:0]       addend_s;
  logic [PW-1:0]       sum_s;
  logic                carry_unused_s;

  // Partial product for the current bit: shifted multiplicand or zero.
  always_comb begin
    if (b_q[cnt_q]) begin
      addend_s = {{NB_BIT{1'b0}}, a_q} << cnt_q;
    end else begin
      addend_s = {PW{1'b0}};
    end
  end

  // The accumulator cannot overflow (max operand product < 2^PW), so the carry is dropped.
  adder_n #(.NB_BIT(PW)) u_acc_add (
    .a_i     (acc_q),
    .b_i     (addend_s),
    .carry_o (carry_unused_s),
    .sum_o   (sum_s)
  );

  // Next-state and datapath update for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rerr_d     = rerr_q;
    prod_d     = prod_q;
    rerr_out_d = rerr_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          acc_d   = {PW{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          rerr_d  = (32'(a_i) >= Q) | (32'(b_i) >= Q);
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_d = sum_s;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          prod_d     = sum_s;
          rerr_out_d = rerr_q;
          state_d    = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          prod_d     = {PW{1'b0}};
          rerr_out_d = 1'b0;
          state_d    = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        prod_d     = {PW{1'b0}};
        rerr_out_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      a_q        <= {NB_BIT{1'b0}};
      b_q        <= {NB_BIT{1'b0}};
      acc_q      <= {PW{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      rerr_q     <= 1'b0;
      prod_q     <= {PW{1'b0}};
      rerr_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rerr_q     <= rerr_d;
      prod_q     <= prod_d;
      rerr_out_q <= rerr_out_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign product_o   = prod_q;
  assign range_err_o = rerr_out_q;

endmodule

// File: tb/tb_mul_k.sv
// Self-checking bench for mul_k: directed Kyber cases plus random operands
// compared against a plain-arithmetic reference.
module tb_mul_k;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [11:0] a_i;
  logic [11:0] b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [23:0] product_o;
  logic        range_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  mul_k dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .product_o   (product_o),
    .range_err_o (range_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_prod(input logic [11:0] a, input logic [11:0] b);
    return 24'(a) * 24'(b);
  endfunction

  function automatic logic ref_err(input logic [11:0] a, input logic [11:0] b);
    return (a >= 12'd3329) || (b >= 12'd3329);
  endfunction

  // One full transaction; hold = cycles out_ready_i stays low in DONE.
  task automatic run_op(input logic [11:0] a, input logic [11:0] b, input int hold);
    logic [23:0] exp_p;
    logic        exp_e;
    int          lat;
    logic        bad;
    exp_p = ref_prod(a, b);
    exp_e = ref_err(a, b);
    @(negedge clk_i);
    a_i        = a;
    b_i        = b;
    in_valid_i = 1'b1;
    chk("in_ready_idle", 32'(in_ready_o), 32'd1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    a_i = 12'($urandom);
    b_i = 12'($urandom);
    lat = 0;
    bad = 1'b0;
    while (!out_valid_o && lat < 40) begin
      if (product_o !== 24'd0 || in_ready_o !== 1'b0 || range_err_o !== 1'b0) bad = 1'b1;
      in_valid_i  = 1'($urandom_range(0, 1));
      out_ready_i = 1'($urandom_range(0, 1));
      a_i = 12'($urandom);
      @(posedge clk_i); #1;
      lat++;
    end
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    chk("latency", 32'(lat), 32'd12);
    chk("busy_outputs", 32'(bad), 32'd0);
    chk("product", 32'(product_o), 32'(exp_p));
    chk("range_err", 32'(range_err_o), 32'(exp_e));
    bad = 1'b0;
    for (int k = 0; k < hold; k++) begin
      in_valid_i = 1'($urandom_range(0, 1));
      a_i = 12'($urandom);
      b_i = 12'($urandom);
      @(posedge clk_i); #1;
      if (product_o !== exp_p || range_err_o !== exp_e ||
          out_valid_o !== 1'b1 || in_ready_o !== 1'b0) bad = 1'b1;
    end
    in_valid_i = 1'b0;
    chk("done_hold", 32'(bad), 32'd0);
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    chk("back_idle", {29'd0, in_ready_o, out_valid_o, range_err_o}, 32'd4);
    chk("idle_product", 32'(product_o), 32'd0);
  endtask

  initial begin
    logic [23:0] qp[$];
    logic        qe[$];
    int          last_acc;
    int          accepted;
    int          got;
    logic        just_acc;
    logic        bad;

    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    a_i         = 12'd0;
    b_i         = 12'd0;
    #1;
    chk("reset_outputs", {28'd0, in_ready_o, out_valid_o, range_err_o, |product_o}, 32'd8);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed Kyber cases.
    run_op(12'd3328, 12'd3328, 3);
    run_op(12'd0,    12'd2047, 0);
    run_op(12'd1234, 12'd2,    1);
    run_op(12'd4095, 12'd4095, 2);
    run_op(12'd100,  12'd33,   20);

    // Reset in the middle of BUSY discards the operation.
    @(negedge clk_i);
    a_i = 12'd3328; b_i = 12'd3328; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid_reset_outputs", {28'd0, in_ready_o, out_valid_o, range_err_o, |product_o}, 32'd8);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk_i); #1;
      if (out_valid_o !== 1'b0 || product_o !== 24'd0) bad = 1'b1;
    end
    chk("no_result_after_reset", 32'(bad), 32'd0);
    run_op(12'd17, 12'd196, 0);

    // Random operands over the full operand range.
    for (int i = 0; i < 8; i++) begin
      run_op(12'($urandom), 12'($urandom), $urandom_range(0, 4));
    end

    // Back-to-back throughput with out_ready_i held high.
    @(posedge clk_i); #1;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    a_i = 12'($urandom);
    b_i = 12'($urandom);
    last_acc = -1;
    accepted = 0;
    got      = 0;
    just_acc = 1'b0;
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      if (out_valid_o) begin
        if (qp.size() > 0) begin
          chk("b2b_product", 32'(product_o), 32'(qp.pop_front()));
          chk("b2b_range_err", 32'(range_err_o), 32'(qe.pop_front()));
        end else begin
          chk("b2b_unexpected_result", 32'd1, 32'(qp.size()));
        end
        got++;
      end
      if (in_ready_o && in_valid_i) begin
        qp.push_back(ref_prod(a_i, b_i));
        qe.push_back(ref_err(a_i, b_i));
        if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'd14);
        last_acc = cyc;
        accepted++;
        just_acc = 1'b1;
      end
      @(posedge clk_i); #1;
      if (just_acc) begin
        a_i = 12'($urandom);
        b_i = 12'($urandom);
        just_acc = 1'b0;
        if (accepted >= 6) in_valid_i = 1'b0;
      end
    end
    out_ready_i = 1'b0;
    in_valid_i  = 1'b0;
    chk("b2b_count", 32'(got), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
